// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: one outstanding memory request, registered decode handoff, redirect/flush.
// Optional YSYX_22041211_IFU_ALIGN_CHECK_EN reports misaligned fetch PCs instead of masking them.
module ysyx_22041211_ifu #(
    parameter int unsigned         DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [DATA_LEN-1:0] req_addr,
    input  logic                rsp_valid,
    input  logic [DATA_LEN-1:0] rsp_data,
    input  logic                rsp_err,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_LEN-1:0] inst,
    output logic [DATA_LEN-1:0] inst_pc,
    output logic                fetch_err,
    output logic                misalign,
    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc
);

`ifdef YSYX_22041211_IFU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    localparam logic [DATA_LEN-1:0] PC_INIT =
        ALIGN_CHECK ? RESET_PC : {RESET_PC[DATA_LEN-1:2], 2'b00};
    localparam logic [DATA_LEN-1:0] PC_STEP = DATA_LEN'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DROP
    } state_t;

    state_t              state;
    logic [DATA_LEN-1:0] pc;
    logic [DATA_LEN-1:0] redir_pc;
    logic [DATA_LEN-1:0] go_pc;
    logic                go_req;
    logic                go_misaligned;

    assign req_addr = pc;

    // Every path that (re)enters REQ is funnelled through go_req/go_pc so the
    // alignment check sees the fetch address exactly once, on entry.
    always_comb begin
        redir_pc = ALIGN_CHECK ? redirect_pc : {redirect_pc[DATA_LEN-1:2], 2'b00};
        go_req   = 1'b0;
        go_pc    = pc;
        case (state)
            S_IDLE: begin
                go_req = 1'b1;
                if (redirect_valid) go_pc = redir_pc;
            end
            S_REQ: begin
                if (redirect_valid && !req_ready) begin
                    go_req = 1'b1;
                    go_pc  = redir_pc;
                end
            end
            S_WAIT: begin
                if (redirect_valid && rsp_valid) begin
                    go_req = 1'b1;
                    go_pc  = redir_pc;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    go_req = 1'b1;
                    go_pc  = redir_pc;
                end else if (inst_ready) begin
                    go_req = 1'b1;
                    go_pc  = pc + PC_STEP;
                end
            end
            S_DROP: begin
                if (rsp_valid) begin
                    go_req = 1'b1;
                    if (redirect_valid) go_pc = redir_pc;
                end
            end
            default: ;
        endcase
        go_misaligned = ALIGN_CHECK && go_req && (go_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= PC_INIT;
            req_valid  <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            fetch_err  <= 1'b0;
            misalign   <= 1'b0;
        end else if (go_req) begin
            pc <= go_pc;
            if (go_misaligned) begin
                state      <= S_OUT;
                req_valid  <= 1'b0;
                inst_valid <= 1'b1;
                inst       <= '0;
                inst_pc    <= go_pc;
                fetch_err  <= 1'b0;
                misalign   <= 1'b1;
            end else begin
                state      <= S_REQ;
                req_valid  <= 1'b1;
                inst_valid <= 1'b0;
                misalign   <= 1'b0;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if (redirect_valid) begin
                            pc    <= redir_pc;
                            state <= S_DROP;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc    <= redir_pc;
                        state <= S_DROP;
                    end else if (rsp_valid) begin
                        state      <= S_OUT;
                        inst_valid <= 1'b1;
                        inst       <= rsp_err ? '0 : rsp_data;
                        inst_pc    <= pc;
                        fetch_err  <= rsp_err;
                        misalign   <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (redirect_valid) pc <= redir_pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Self-checking bench for ysyx_22041211_ifu: directed cycle table plus randomized run against a fetch-stream model.
module tb_ysyx_22041211_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        fetch_err, misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    ysyx_22041211_ifu #(
        .DATA_LEN(32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .fetch_err     (fetch_err),
        .misalign      (misalign),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic        vin;
        logic [31:0] rd;
        logic        re;
        logic        ir;
        logic        xv;
        logic [31:0] xp;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_fe;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(input logic [31:0] rr, vin, rd, re, ir, xv, xp,
                                input logic [31:0] e_rv, e_ra, e_iv, e_inst, e_ipc, e_fe);
        vec_t v;
        v.rr = rr[0]; v.vin = vin[0]; v.rd = rd; v.re = re[0]; v.ir = ir[0];
        v.xv = xv[0]; v.xp = xp; v.e_rv = e_rv[0]; v.e_ra = e_ra; v.e_iv = e_iv[0];
        v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_fe = e_fe[0];
        return v;
    endfunction

    // Layout: {pad, misalign, req_valid, req_addr, inst_valid, inst, inst_pc, fetch_err}
    function automatic logic [127:0] pack(input logic mis, rv, input logic [31:0] ra,
                                          input logic iv, input logic [31:0] in, ipc,
                                          input logic fe);
        return {28'h0, mis, rv, ra, iv, in, ipc, fe};
    endfunction

    function automatic logic [127:0] snap();
        return pack(misalign, req_valid, req_addr, inst_valid, inst, inst_pc, fetch_err);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[6:2] == 5'h13;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_idle();
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] model_pc, pend_addr, exp_word;
        logic        out, out_before, resp_now, req_fire, inst_fire;
        logic        prev_rv, prev_rr, prev_xv, prev_iv, prev_ir;
        logic [31:0] prev_ra, prev_inst, prev_ipc;
        logic        prev_fe;
        int unsigned cnt, deliveries, gap, max_gap, wrap_seen, quiet;

        tbl[0]  = mk(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 0,            0, 32'h8000_0000, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0,                        1, 32'h8000_0000, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 32'h0010_0093, 0, 0, 0, 0,            0, 32'h8000_0000, 0, 0, 0, 0);
        for (int i = 3; i < 8; i++)
            tbl[i] = mk(0, 0, 0, 0, 0, 0, 0,                     0, 32'h8000_0000, 1, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0,                        0, 32'h8000_0000, 1, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,                        1, 32'h8000_0004, 0, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0,                        1, 32'h8000_0004, 0, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 32'h8000_0100,            0, 32'h8000_0004, 0, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,                        0, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[13] = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0,            0, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0,                        1, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[15] = mk(0, 1, 32'h1234_5678, 0, 0, 0, 0,            0, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0000, 0);
        tbl[16] = mk(0, 0, 0, 0, 1, 1, 32'h8000_0200,            0, 32'h8000_0100, 1, 32'h1234_5678, 32'h8000_0100, 0);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 0,                        1, 32'h8000_0200, 0, 32'h1234_5678, 32'h8000_0100, 0);
        tbl[18] = mk(0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0,            0, 32'h8000_0200, 0, 32'h1234_5678, 32'h8000_0100, 0);
        tbl[19] = mk(0, 0, 0, 0, 1, 0, 0,                        0, 32'h8000_0200, 1, 0, 32'h8000_0200, 1);
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 0,                        1, 32'h8000_0204, 0, 0, 32'h8000_0200, 1);
        tbl[21] = mk(0, 1, 32'h0000_0013, 0, 0, 0, 0,            0, 32'h8000_0204, 0, 0, 32'h8000_0200, 1);
        tbl[22] = mk(0, 0, 0, 0, 1, 0, 0,                        0, 32'h8000_0204, 1, 32'h13, 32'h8000_0204, 0);
        tbl[23] = mk(0, 0, 0, 0, 0, 1, 32'h8000_0300,            1, 32'h8000_0208, 0, 32'h13, 32'h8000_0204, 0);
        tbl[24] = mk(1, 0, 0, 0, 0, 1, 32'h8000_0400,            1, 32'h8000_0300, 0, 32'h13, 32'h8000_0204, 0);
        tbl[25] = mk(0, 1, 32'hAAAA_5555, 0, 0, 0, 0,            0, 32'h8000_0400, 0, 32'h13, 32'h8000_0204, 0);
        tbl[26] = mk(1, 0, 0, 0, 0, 0, 0,                        1, 32'h8000_0400, 0, 32'h13, 32'h8000_0204, 0);
        tbl[27] = mk(0, 1, 32'h1111_1111, 0, 0, 1, 32'h8000_0500, 0, 32'h8000_0400, 0, 32'h13, 32'h8000_0204, 0);
        tbl[28] = mk(0, 0, 0, 0, 0, 0, 0,                        1, 32'h8000_0500, 0, 32'h13, 32'h8000_0204, 0);

        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        check("reset_state", snap(), pack(0, 0, RST_PC, 0, 0, 0, 0));

        rst_n = 1'b1;
        for (int i = 0; i < 29; i++) begin
            check($sformatf("vec%0d", i), snap(),
                  pack(0, tbl[i].e_rv, tbl[i].e_ra, tbl[i].e_iv, tbl[i].e_inst, tbl[i].e_ipc, tbl[i].e_fe));
            req_ready = tbl[i].rr; rsp_valid = tbl[i].vin; rsp_data = tbl[i].rd; rsp_err = tbl[i].re;
            inst_ready = tbl[i].ir; redirect_valid = tbl[i].xv; redirect_pc = tbl[i].xp;
            @(negedge clk);
        end

        // Misaligned redirect while parked in REQ.
        drive_idle();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef YSYX_22041211_IFU_ALIGN_CHECK_EN
        check("align_redirect", snap(), pack(1, 0, 32'h8000_0002, 1, 0, 32'h8000_0002, 0));
        @(negedge clk);
        check("align_hold", snap(), pack(1, 0, 32'h8000_0002, 1, 0, 32'h8000_0002, 0));
`else
        check("align_redirect", snap(), pack(0, 1, 32'h8000_0000, 0, 32'h13, 32'h8000_0204, 0));
        @(negedge clk);
        check("align_hold", snap(), pack(0, 1, 32'h8000_0000, 0, 32'h13, 32'h8000_0204, 0));
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("align_recover", 128'({misalign, req_valid, req_addr, inst_valid}),
              128'({1'b0, 1'b1, 32'h8000_1000, 1'b0}));

        // Asynchronous reset with a request outstanding, response arriving in IDLE.
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", snap(), pack(0, 0, RST_PC, 0, 0, 0, 0));
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("post_reset", snap(), pack(0, 1, RST_PC, 0, 0, 0, 0));

        // Randomized run: the model only tracks the address of the next instruction owed to decode.
        model_pc = RST_PC; out = 1'b0; pend_addr = '0; cnt = 0;
        deliveries = 0; gap = 0; max_gap = 0; wrap_seen = 0; quiet = 0;
        prev_rv = 1'b0; prev_rr = 1'b0; prev_xv = 1'b0; prev_iv = 1'b0; prev_ir = 1'b0;
        prev_ra = '0; prev_inst = '0; prev_ipc = '0; prev_fe = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_rv && !prev_rr && !prev_xv)
                check("req_stable", 128'({req_valid, req_addr}), 128'({1'b1, prev_ra}));
            if (prev_iv && !prev_ir && !prev_xv)
                check("inst_stable", 128'({inst_valid, inst, inst_pc, fetch_err}),
                      128'({1'b1, prev_inst, prev_ipc, prev_fe}));
            if (req_valid) check("req_addr", 128'(req_addr), 128'(model_pc));
            gap = inst_valid ? 0 : gap + 1;
            if (gap > max_gap) max_gap = gap;

            req_ready  = ($urandom_range(0, 9) < 6);
            inst_ready = ($urandom_range(0, 3) != 0);
            rsp_data   = $urandom;
            rsp_err    = $urandom_range(0, 1) == 1;
            rsp_valid  = 1'b0;
            resp_now   = 1'b0;
            if (out) begin
                if (cnt == 0) begin
                    resp_now  = 1'b1;
                    rsp_valid = 1'b1;
                    rsp_data  = mem_word(pend_addr);
                    rsp_err   = mem_err(pend_addr);
                end else begin
                    cnt--;
                end
            end
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
            if (cyc == 100) begin
                redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; quiet = 60;
            end else if (quiet != 0) begin
                quiet--;
            end else if ($urandom_range(0, 31) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                            : 32'h8000_0000 + ($urandom_range(0, 4095) << 2);
            end

            req_fire  = req_valid && req_ready;
            inst_fire = inst_valid && inst_ready;
            if (inst_fire && !redirect_valid) begin
                exp_word = mem_err(model_pc) ? 32'h0 : mem_word(model_pc);
                check("deliver", 128'({inst, inst_pc, fetch_err, misalign}),
                      128'({exp_word, model_pc, mem_err(model_pc), 1'b0}));
                if (model_pc == 32'h0 && deliveries != 0) wrap_seen++;
                model_pc   = model_pc + 32'd4;
                deliveries++;
            end
            if (redirect_valid) model_pc = redirect_pc;
            out_before = out;
            if (resp_now) out = 1'b0;
            if (req_fire) begin
                check("one_outstanding", 128'(out_before), 128'(0));
                out       = 1'b1;
                pend_addr = req_addr;
                cnt       = $urandom_range(0, 2);
            end

            prev_rv = req_valid; prev_rr = req_ready; prev_xv = redirect_valid;
            prev_iv = inst_valid; prev_ir = inst_ready; prev_ra = req_addr;
            prev_inst = inst; prev_ipc = inst_pc; prev_fe = fetch_err;
            @(negedge clk);
        end
        drive_idle();

        check("progress", 128'(deliveries > 100), 128'(1));
        check("max_gap", 128'(max_gap < 200), 128'(1));
        check("pc_wrap", 128'(wrap_seen > 0), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
